mem_stage_hs: RTL and testbench

//  Parametrised MEM pipeline stage between EXE and WB for a data bus with variable latency.

---
 rtl/mem_stage_hs_pkg.sv | 22 ++
 rtl/mem_stage_hs_load_align.sv | 28 ++
 rtl/mem_stage_hs.sv | 121 ++++++++++++
 tb/tb_mem_stage_hs.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_hs_pkg.sv
// mem_stage_hs_pkg: memory-op encodings, FSM states and bus-width helpers for the MEM stage
package mem_stage_hs_pkg;
    localparam logic [1:0] MEM_OP_B = 2'd0;
    localparam logic [1:0] MEM_OP_H = 2'd1;
    localparam logic [1:0] MEM_OP_W = 2'd2;
    localparam logic [1:0] MEM_OP_D = 2'd3;
    localparam int MEM_OP_UNS = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} ms_state_t;

    function automatic int es_to_ms_bus_wd(input int xlen, input int aw);
        return 6 + aw + 2 * xlen;
    endfunction

    function automatic int ms_to_ws_bus_wd(input int xlen, input int aw);
        return 1 + aw + 2 * xlen;
    endfunction

    function automatic int ms_fwd_bus_wd(input int xlen, input int aw);
        return 2 + aw + xlen;
    endfunction
endpackage

// File: rtl/mem_stage_hs_load_align.sv
// mem_stage_hs_load_align: picks the addressed lane of a read word and sign/zero-extends it
module mem_stage_hs_load_align
    import mem_stage_hs_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AL_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [AL_W-1:0] i_addr_lo,
    input  logic [2:0]      i_mem_op,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_top;
    logic [6:0]      w_bits;
    logic            w_sign;

    assign w_sh   = i_rdata >> {i_addr_lo, 3'b000};
    assign w_bits = i_mem_op[1:0] == MEM_OP_B ? 7'd8  :
                    i_mem_op[1:0] == MEM_OP_H ? 7'd16 :
                    i_mem_op[1:0] == MEM_OP_W ? 7'd32 : 7'd64;
    // a shift of XLEN or more yields an all-ones mask, so full-width loads pass through
    assign w_mask = ~({XLEN{1'b1}} << w_bits);
    assign w_top  = w_mask & ~(w_mask >> 1);
    assign w_sign = !i_mem_op[MEM_OP_UNS] && |(w_sh & w_top);
    assign o_data = (w_sh & w_mask) | ({XLEN{w_sign}} & ~w_mask);
endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage that waits for variable-latency data responses,
// aligns loads, forwards results and discards responses of flushed requests.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int DISCARD_W = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_ws_allowin,
    output logic                                      o_ms_allowin,
    input  logic                                      i_ms_flush,
    input  logic                                      i_es_to_ms_valid,
    input  logic [es_to_ms_bus_wd(XLEN, REG_AW)-1:0]  i_es_to_ms_bus,
    output logic                                      o_ms_to_ws_valid,
    output logic [ms_to_ws_bus_wd(XLEN, REG_AW)-1:0]  o_ms_to_ws_bus,
    output logic [ms_fwd_bus_wd(XLEN, REG_AW)-1:0]    o_ms_fwd_bus,
    input  logic                                      i_data_sram_data_ok,
    input  logic [XLEN-1:0]                           i_data_sram_rdata
);
    localparam int AL_W = $clog2(XLEN / 8);
    localparam int ES_W = es_to_ms_bus_wd(XLEN, REG_AW);

    ms_state_t             r_state;
    ms_state_t             w_state_nx;
    logic                  r_valid;
    logic                  w_valid_nx;
    logic [ES_W-1:0]       r_bus;
    logic [XLEN-1:0]       r_rdata_buf;
    logic                  r_rdata_vld;
    logic [DISCARD_W-1:0]  r_discard_cnt;

    logic [XLEN-1:0]   w_pc;
    logic [XLEN-1:0]   w_exe_result;
    logic [REG_AW-1:0] w_dest;
    logic              w_gr_we;
    logic              w_load_op;
    logic [2:0]        w_mem_op;
    logic [XLEN-1:0]   w_aligned;
    logic [XLEN-1:0]   w_final;
    logic              w_enter;
    logic              w_leave;
    logic              w_resp;
    logic              w_inc;
    logic              w_dec;

    assign w_pc         = r_bus[XLEN-1:0];
    assign w_exe_result = r_bus[2*XLEN-1:XLEN];
    assign w_dest       = r_bus[2*XLEN+REG_AW-1:2*XLEN];
    assign w_gr_we      = r_bus[ES_W-6];
    assign w_load_op    = r_bus[ES_W-5];
    assign w_mem_op     = r_bus[ES_W-1:ES_W-3];

    assign o_ms_allowin = !r_valid || (r_state == ST_DONE && i_ws_allowin);
    assign w_enter      = i_es_to_ms_valid && o_ms_allowin && !i_ms_flush;
    assign w_leave      = r_valid && r_state == ST_DONE && i_ws_allowin;
    // a response belongs to the held request only once all cancelled ones have drained
    assign w_resp       = i_data_sram_data_ok && r_state == ST_WAIT && r_discard_cnt == '0;
    assign w_inc        = i_ms_flush && r_state == ST_WAIT && !w_resp;
    assign w_dec        = i_data_sram_data_ok && r_discard_cnt != '0;

    mem_stage_hs_load_align #(.XLEN(XLEN), .AL_W(AL_W)) u_align (
        .i_rdata   (i_data_sram_rdata),
        .i_addr_lo (w_exe_result[AL_W-1:0]),
        .i_mem_op  (w_mem_op),
        .o_data    (w_aligned)
    );

    always_comb begin
        w_valid_nx = r_valid;
        w_state_nx = r_state;
        if (i_ms_flush) begin
            w_valid_nx = 1'b0;
            w_state_nx = ST_IDLE;
        end else if (w_enter) begin
            w_valid_nx = 1'b1;
            w_state_nx = i_es_to_ms_bus[ES_W-4] ? ST_WAIT : ST_DONE;
        end else if (w_leave) begin
            w_valid_nx = 1'b0;
            w_state_nx = ST_IDLE;
        end else if (w_resp) begin
            w_state_nx = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_valid <= w_valid_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus         <= '0;
            r_rdata_buf   <= '0;
            r_rdata_vld   <= 1'b0;
            r_discard_cnt <= '0;
        end else begin
            r_discard_cnt <= r_discard_cnt + DISCARD_W'(w_inc) - DISCARD_W'(w_dec);
            if (w_enter)
                r_bus <= i_es_to_ms_bus;
            if (w_enter || i_ms_flush) begin
                r_rdata_vld <= 1'b0;
            end else if (w_resp) begin
                r_rdata_vld <= 1'b1;
                r_rdata_buf <= w_aligned;
            end
        end
    end

    assign w_final          = (w_load_op && r_rdata_vld) ? r_rdata_buf : w_exe_result;
    assign o_ms_to_ws_valid = r_valid && r_state == ST_DONE && !i_ms_flush;
    assign o_ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
    assign o_ms_fwd_bus     = {r_valid && w_gr_we, r_state == ST_DONE, w_dest, w_final};
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed vectors for mem_stage_hs with hand-computed expected results
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        ms_flush;
    logic        es_valid;
    logic [74:0] es_bus;
    logic        to_ws_valid;
    logic [69:0] to_ws_bus;
    logic [38:0] fwd_bus;
    logic        data_ok;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;

    mem_stage_hs dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_ws_allowin        (ws_allowin),
        .o_ms_allowin        (ms_allowin),
        .i_ms_flush          (ms_flush),
        .i_es_to_ms_valid    (es_valid),
        .i_es_to_ms_bus      (es_bus),
        .o_ms_to_ws_valid    (to_ws_valid),
        .o_ms_to_ws_bus      (to_ws_bus),
        .o_ms_fwd_bus        (fwd_bus),
        .i_data_sram_data_ok (data_ok),
        .i_data_sram_rdata   (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n)
            assert (!(dut.w_inc && !dut.w_dec && &dut.r_discard_cnt))
                else $error("discard counter overflow");

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [74:0] mk(input logic [2:0] op, input logic rq, input logic ld,
                                       input logic we, input logic [4:0] d,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {op, rq, ld, we, d, res, pc};
    endfunction

    task automatic do_mem(input string tag, input logic [2:0] op, input logic ld,
                          input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] exp);
        es_valid   = 1'b1;
        es_bus     = mk(op, 1'b1, ld, ld, 5'd7, addr, 32'h2000);
        ws_allowin = 1'b1;
        #1 check({tag, "_allowin_idle"}, ms_allowin, 1'b1);
        tick();
        es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_ok = (i == 2);
            rdata   = rd;
            #1;
            check({tag, "_stall"}, ms_allowin, 1'b0);
            check({tag, "_no_valid"}, to_ws_valid, 1'b0);
            tick();
        end
        data_ok = 1'b0;
        #1;
        check({tag, "_valid"}, to_ws_valid, 1'b1);
        check({tag, "_result"}, to_ws_bus[63:32], exp);
        check({tag, "_fwd_ready"}, fwd_bus[37], 1'b1);
        tick();
        check({tag, "_left"}, to_ws_valid, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ws_allowin = 1'b0;
        ms_flush   = 1'b0;
        es_valid   = 1'b0;
        es_bus     = '0;
        data_ok    = 1'b0;
        rdata      = '0;
        #1;
        check("rst_to_ws_valid", to_ws_valid, 1'b0);
        check("rst_allowin", ms_allowin, 1'b1);
        check("rst_fwd_valid", fwd_bus[38], 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        es_valid   = 1'b1;
        es_bus     = mk(3'b010, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h100);
        ws_allowin = 1'b1;
        tick();
        es_valid = 1'b0;
        #1;
        check("alu_valid", to_ws_valid, 1'b1);
        check("alu_bus", to_ws_bus, {1'b1, 5'd3, 32'h1234_5678, 32'h100});
        check("alu_fwd", fwd_bus, {1'b1, 1'b1, 5'd3, 32'h1234_5678});
        check("alu_allowin", ms_allowin, 1'b1);
        tick();
        check("alu_left", to_ws_valid, 1'b0);

        do_mem("lb",  3'b000, 1'b1, 32'h1003, 32'h80AA_BBCC, 32'hFFFF_FF80);
        do_mem("lbu", 3'b100, 1'b1, 32'h1003, 32'h80AA_BBCC, 32'h0000_0080);
        do_mem("lh",  3'b001, 1'b1, 32'h1002, 32'h8001_7FFF, 32'hFFFF_8001);
        do_mem("lhu", 3'b101, 1'b1, 32'h1002, 32'h8001_7FFF, 32'h0000_8001);
        do_mem("lh0", 3'b001, 1'b1, 32'h1000, 32'h8001_7FFF, 32'h0000_7FFF);
        do_mem("lw",  3'b010, 1'b1, 32'h1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_mem("sw",  3'b010, 1'b0, 32'h0500, 32'hFFFF_FFFF, 32'h0000_0500);

        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd4, 32'h100, 32'h10);
        tick();
        es_valid = 1'b0;
        ms_flush = 1'b1;
        #1 check("fl_to_ws_valid", to_ws_valid, 1'b0);
        tick();
        ms_flush = 1'b0;
        check("fl_cnt_inc", dut.r_discard_cnt, 2'd1);
        check("fl_cleared", fwd_bus[38], 1'b0);
        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd5, 32'h200, 32'h14);
        tick();
        es_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h1111_1111;
        tick();
        data_ok = 1'b0;
        check("d1_cnt_dec", dut.r_discard_cnt, 2'd0);
        check("d1_dropped", to_ws_valid, 1'b0);
        check("d1_stall", ms_allowin, 1'b0);
        data_ok = 1'b1;
        rdata   = 32'h2222_2222;
        tick();
        data_ok = 1'b0;
        #1;
        check("d2_valid", to_ws_valid, 1'b1);
        check("d2_result", to_ws_bus[63:32], 32'h2222_2222);
        tick();

        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd6, 32'h300, 32'h18);
        tick();
        es_valid = 1'b0;
        ms_flush = 1'b1;
        data_ok  = 1'b1;
        rdata    = 32'h3333_3333;
        tick();
        ms_flush = 1'b0;
        data_ok  = 1'b0;
        check("fldok_cnt", dut.r_discard_cnt, 2'd0);
        check("fldok_cleared", fwd_bus[38], 1'b0);
        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd6, 32'h304, 32'h1C);
        tick();
        es_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h4444_4444;
        tick();
        data_ok = 1'b0;
        #1;
        check("fldok_own_resp", to_ws_bus[63:32], 32'h4444_4444);
        tick();

        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b0, 1'b0, 1'b1, 5'd8, 32'h55, 32'h20);
        tick();
        es_valid = 1'b0;
        ms_flush = 1'b1;
        #1 check("fl_done_gated", to_ws_valid, 1'b0);
        tick();
        ms_flush = 1'b0;
        check("fl_done_cnt", dut.r_discard_cnt, 2'd0);
        check("fl_done_cleared", fwd_bus[38], 1'b0);

        ws_allowin = 1'b0;
        es_valid   = 1'b1;
        es_bus     = mk(3'b010, 1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA_0001, 32'h3000);
        tick();
        es_bus = mk(3'b010, 1'b0, 1'b0, 1'b0, 5'd10, 32'hBBBB_0002, 32'h3004);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hold_allowin", ms_allowin, 1'b0);
            check("hold_valid", to_ws_valid, 1'b1);
            check("hold_bus", to_ws_bus, {1'b1, 5'd9, 32'hAAAA_0001, 32'h3000});
            tick();
        end
        ws_allowin = 1'b1;
        #1 check("handover_allowin", ms_allowin, 1'b1);
        tick();
        es_valid = 1'b0;
        #1;
        check("handover_valid", to_ws_valid, 1'b1);
        check("handover_bus", to_ws_bus, {1'b0, 5'd10, 32'hBBBB_0002, 32'h3004});
        check("handover_fwd_valid", fwd_bus[38], 1'b0);
        tick();

        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd11, 32'h400, 32'h40);
        tick();
        es_valid = 1'b0;
        ms_flush = 1'b1;
        tick();
        ms_flush = 1'b0;
        es_valid = 1'b1;
        es_bus   = mk(3'b010, 1'b1, 1'b1, 1'b1, 5'd12, 32'h404, 32'h44);
        tick();
        es_valid = 1'b0;
        check("pre_rst_cnt", dut.r_discard_cnt, 2'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wait_cnt", dut.r_discard_cnt, 2'd0);
        check("rst_wait_fwd", fwd_bus[38], 1'b0);
        check("rst_wait_allowin", ms_allowin, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
